// File: rtl/ie_pkg.sv
// Shared definitions for the interrupt/exception entry sequencer: state encoding,
// cause codes and the default handler vectors.
package ie_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StEnter   = 2'd1,
        StHandler = 2'd2,
        StReturn  = 2'd3
    } ie_state_e;

    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_IRQ   = 2'b01;
    localparam logic [1:0] CAUSE_UNDEF = 2'b10;

    localparam logic [31:0] IRQ_VECTOR_DEFAULT = 32'h8000_0004;
    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h8000_0008;

endpackage

// File: rtl/ie_irq_latch.sv
// External interrupt rise detector with a sticky pending bit. Pending is set by a
// detected rise and cleared only when the sequencer accepts the interrupt.
module ie_irq_latch (
    input  logic clk,
    input  logic reset,
    input  logic irq,
    input  logic clr,
    output logic rise,
    output logic pending
);

    logic irq_q, irq_d;
    logic armed_q, armed_d;
    logic pending_q, pending_d;

    // A level already high when reset is released must not look like a rise.
    assign rise    = irq & ~irq_q & armed_q;
    assign pending = pending_q;

    always_comb begin
        irq_d     = irq;
        armed_d   = 1'b1;
        pending_d = (pending_q | rise) & ~clr;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_q     <= 1'b0;
            armed_q   <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            irq_q     <= irq_d;
            armed_q   <= armed_d;
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/ie_sequencer.sv
// Interrupt/exception entry and eret return sequencer for the 5-stage MIPS32 pipe.
// Optional IE_STATS_EN adds wrapping irq/exception entry counters.
module ie_sequencer
    import ie_pkg::*;
#(
    parameter logic [31:0] IRQ_VECTOR = IRQ_VECTOR_DEFAULT,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
    parameter int unsigned CAUSE_W    = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               irq,
    input  logic               exc_undef,
    input  logic               eret,
    input  logic [31:0]        PC_IE,
    output logic               pc_redirect,
    output logic [31:0]        pc_target,
    output logic               flush_IFID,
    output logic               flush_IDEX,
    output logic [31:0]        epc,
    output logic [CAUSE_W-1:0] cause,
    output logic               kernel
`ifdef IE_STATS_EN
    ,
    output logic [15:0]        irq_count,
    output logic [15:0]        exc_count
`endif
);

    localparam logic [CAUSE_W-1:0] CauseNone  = CAUSE_W'(CAUSE_NONE);
    localparam logic [CAUSE_W-1:0] CauseIrq   = CAUSE_W'(CAUSE_IRQ);
    localparam logic [CAUSE_W-1:0] CauseUndef = CAUSE_W'(CAUSE_UNDEF);

    ie_state_e          state_q, state_d;
    logic [31:0]        epc_q, epc_d;
    logic [CAUSE_W-1:0] cause_q, cause_d;
    logic               kernel_q, kernel_d;
    logic               redirect_q, redirect_d;
    logic [31:0]        target_q, target_d;
    logic               flush_ifid_q, flush_ifid_d;
    logic               flush_idex_q, flush_idex_d;

    logic irq_rise;
    logic irq_pending;
    logic irq_clr;

    ie_irq_latch u_irq_latch (
        .clk     (clk),
        .reset   (reset),
        .irq     (irq),
        .clr     (irq_clr),
        .rise    (irq_rise),
        .pending (irq_pending)
    );

    always_comb begin
        state_d      = state_q;
        epc_d        = epc_q;
        cause_d      = cause_q;
        kernel_d     = kernel_q;
        redirect_d   = 1'b0;
        target_d     = 32'h0;
        flush_ifid_d = 1'b0;
        flush_idex_d = 1'b0;
        irq_clr      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (exc_undef) begin
                    epc_d   = PC_IE;
                    cause_d = CauseUndef;
                    state_d = StEnter;
                end else if (irq_pending || irq_rise) begin
                    epc_d   = PC_IE;
                    cause_d = CauseIrq;
                    irq_clr = 1'b1;
                    state_d = StEnter;
                end
            end
            StEnter: begin
                kernel_d = 1'b1;
                state_d  = StHandler;
            end
            StHandler: begin
                if (eret) begin
                    state_d = StReturn;
                end
            end
            StReturn: begin
                kernel_d = 1'b0;
                cause_d  = CauseNone;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Redirect/flush outputs are registered, so decode them from the next state.
        if (state_d == StEnter) begin
            redirect_d   = 1'b1;
            target_d     = (cause_d == CauseUndef) ? EXC_VECTOR : IRQ_VECTOR;
            flush_ifid_d = 1'b1;
            flush_idex_d = 1'b1;
        end else if (state_d == StReturn) begin
            redirect_d   = 1'b1;
            target_d     = epc_q;
            flush_ifid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            epc_q        <= 32'h0;
            cause_q      <= CauseNone;
            kernel_q     <= 1'b0;
            redirect_q   <= 1'b0;
            target_q     <= 32'h0;
            flush_ifid_q <= 1'b0;
            flush_idex_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            epc_q        <= epc_d;
            cause_q      <= cause_d;
            kernel_q     <= kernel_d;
            redirect_q   <= redirect_d;
            target_q     <= target_d;
            flush_ifid_q <= flush_ifid_d;
            flush_idex_q <= flush_idex_d;
        end
    end

    assign pc_redirect = redirect_q;
    assign pc_target   = target_q;
    assign flush_IFID  = flush_ifid_q;
    assign flush_IDEX  = flush_idex_q;
    assign epc         = epc_q;
    assign cause       = cause_q;
    assign kernel      = kernel_q;

`ifdef IE_STATS_EN
    logic [15:0] irq_count_q, irq_count_d;
    logic [15:0] exc_count_q, exc_count_d;
    logic        entering;

    always_comb begin
        entering    = (state_q == StIdle) && (state_d == StEnter);
        irq_count_d = irq_count_q;
        exc_count_d = exc_count_q;
        if (entering && (cause_d == CauseIrq)) begin
            irq_count_d = irq_count_q + 16'd1;
        end
        if (entering && (cause_d == CauseUndef)) begin
            exc_count_d = exc_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_count_q <= 16'h0;
            exc_count_q <= 16'h0;
        end else begin
            irq_count_q <= irq_count_d;
            exc_count_q <= exc_count_d;
        end
    end

    assign irq_count = irq_count_q;
    assign exc_count = exc_count_q;
`endif

endmodule
